// File: rtl/bridge_pkg.sv
// bridge_pkg: receiver state encoding and the ASCII bytes of the hex bus protocol.
package bridge_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, TERM} state_t;

   localparam logic [7:0] ASCII_R    = 8'h52;
   localparam logic [7:0] ASCII_W    = 8'h57;
   localparam logic [7:0] ASCII_R_LC = 8'h72;
   localparam logic [7:0] ASCII_W_LC = 8'h77;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/hex_to_nibble.sv
// hex_to_nibble: ASCII hex digit to 4-bit value; BRIDGE_RX_LOWERCASE_EN also admits a-f.
module hex_to_nibble (
   input  logic [7:0] code,
   output logic [3:0] nibble,
   output logic       is_hex
);

   logic is_dig, is_up, is_lo;

   assign is_dig = code >= 8'h30 && code <= 8'h39;
   assign is_up  = code >= 8'h41 && code <= 8'h46;
`ifdef BRIDGE_RX_LOWERCASE_EN
   assign is_lo  = code >= 8'h61 && code <= 8'h66;
`else
   assign is_lo  = 1'b0;
`endif

   // Both 'A' and 'a' have low nibble 1, so letters need only a +9 offset.
   assign nibble = is_dig ? code[3:0] : code[3:0] + 4'd9;
   assign is_hex = is_dig | is_up | is_lo;

endmodule

// File: rtl/bridge_rx.sv
// bridge_rx: decodes ASCII "R<addr>" / "W<addr><data>" + CR/LF into a one-cycle bus request.
// Build option BRIDGE_RX_LOWERCASE_EN accepts lowercase opcodes and hex digits.
module bridge_rx
   import bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            data_i,
   input  logic                  valid_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  rw_o,
   output logic                  valid_o
);

   localparam int AD   = ADDR_WIDTH / 4;
   localparam int DD   = DATA_WIDTH / 4;
   localparam int MAXD = AD > DD ? AD : DD;
   localparam int CW   = $clog2(MAXD + 1);

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] addr_sh;
   logic [DATA_WIDTH-1:0] data_sh;
   logic                  rw_sh;
   logic [3:0]            nib;
   logic                  is_hex, is_term, is_rd, is_wr, last_a, last_d;

   hex_to_nibble u_hex (
      .code   (data_i),
      .nibble (nib),
      .is_hex (is_hex)
   );

   assign is_term = data_i == ASCII_CR || data_i == ASCII_LF;
`ifdef BRIDGE_RX_LOWERCASE_EN
   assign is_rd = data_i == ASCII_R || data_i == ASCII_R_LC;
   assign is_wr = data_i == ASCII_W || data_i == ASCII_W_LC;
`else
   assign is_rd = data_i == ASCII_R;
   assign is_wr = data_i == ASCII_W;
`endif
   assign last_a = cnt == CW'(AD - 1);
   assign last_d = cnt == CW'(DD - 1);

   // Any unexpected byte sends the FSM back to IDLE; the shadow registers are
   // only copied to the outputs on a correctly terminated message.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_sh <= '0;
         data_sh <= '0;
         rw_sh   <= 1'b0;
         addr_o  <= '0;
         data_o  <= '0;
         rw_o    <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (valid_i) begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (is_rd || is_wr) begin
                     state   <= ADDR;
                     rw_sh   <= is_wr;
                     addr_sh <= '0;
                     data_sh <= '0;
                  end
               end
               ADDR: begin
                  if (!is_hex) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     addr_sh <= (addr_sh << 4) | ADDR_WIDTH'(nib);
                     cnt     <= last_a ? '0 : cnt + CW'(1);
                     if (last_a) state <= rw_sh ? DATA : TERM;
                  end
               end
               DATA: begin
                  if (!is_hex) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     data_sh <= (data_sh << 4) | DATA_WIDTH'(nib);
                     cnt     <= last_d ? '0 : cnt + CW'(1);
                     if (last_d) state <= TERM;
                  end
               end
               TERM: begin
                  state <= IDLE;
                  cnt   <= '0;
                  if (is_term) begin
                     valid_o <= 1'b1;
                     addr_o  <= addr_sh;
                     data_o  <= rw_sh ? data_sh : '0;
                     rw_o    <= rw_sh;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bridge_rx.sv
// tb_bridge_rx: directed ASCII messages with a scoreboard of expected bus requests.
module tb_bridge_rx;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
      logic        rw;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_i;
   logic        valid_i;
   logic [15:0] addr_o;
   logic [15:0] data_o;
   logic        rw_o;
   logic        valid_o;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        prev_v = 1'b0;
   logic [15:0] m_addr = '0;
   logic [15:0] m_data = '0;
   logic        m_rw   = 1'b0;

   bridge_rx #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_i),
      .valid_i (valid_i),
      .addr_o  (addr_o),
      .data_o  (data_o),
      .rw_o    (rw_o),
      .valid_o (valid_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid_o) begin
         checks++;
         assert (prev_v === 1'b0) else begin
            errors++;
            $error("FAIL pulse_width observed=2+ cycles expected=1 cycle");
         end
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pulse observed addr=%h data=%h rw=%b expected=no pulse", addr_o, data_o, rw_o);
         end
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            assert (addr_o === e.a) else begin
               errors++;
               $error("FAIL pulse_addr observed=%h expected=%h", addr_o, e.a);
            end
            checks++;
            assert (data_o === e.d) else begin
               errors++;
               $error("FAIL pulse_data observed=%h expected=%h", data_o, e.d);
            end
            checks++;
            assert (rw_o === e.rw) else begin
               errors++;
               $error("FAIL pulse_rw observed=%b expected=%b", rw_o, e.rw);
            end
         end
      end
      prev_v = valid_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      data_i  = b;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic expect_req(input logic [15:0] a, input logic [15:0] d, input logic rw);
      exp_q.push_back('{a: a, d: d, rw: rw});
      m_addr = a;
      m_data = d;
      m_rw   = rw;
   endtask

   task automatic drain(input string tag);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_pending"}, exp_q.size(), 0);
      chk({tag, "_hold_addr"}, addr_o, m_addr);
      chk({tag, "_hold_data"}, data_o, m_data);
      chk({tag, "_hold_rw"}, rw_o, m_rw);
   endtask

   initial begin
      rst     = 1'b1;
      data_i  = 8'h00;
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr", addr_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_rw", rw_o, 0);
      chk("rst_valid", valid_o, 0);
      rst = 1'b0;
      send_str("\r\nxZ");
      drain("idle_junk");

      expect_req(16'h0002, 16'h0000, 1'b0);
      send_str("R0002");
      send(8'h0D);
      chk("r0002_strobe_next_cycle", valid_o, 1);
      @(posedge clk);
      #1;
      chk("r0002_strobe_one_cycle", valid_o, 0);
      drain("r0002");

      expect_req(16'h1234, 16'h5678, 1'b1);
      send_str("W12345678\n");
      drain("w1234");

      // the 'W' lands in the cycle the read strobe is high
      expect_req(16'h0003, 16'h0000, 1'b0);
      send_str("R0003\r");
      expect_req(16'h00AB, 16'h00CD, 1'b1);
      send_str("W00AB00CD\r");
      drain("back_to_back");

      send_str("R12G4\r");
      expect_req(16'h00FF, 16'h0000, 1'b0);
      send_str("R00FF\r");
      drain("bad_digit");

      send_str("R00011\r");
      send_str("W1234\r");
      send_str("R0W12\r");
      drain("wrong_length");

`ifdef BRIDGE_RX_LOWERCASE_EN
      expect_req(16'h00AB, 16'h0000, 1'b0);
`endif
      send_str("r00ab\r");
      drain("lowercase");

      send_str("W12");
      rst = 1'b1;
      #1;
      m_addr = '0;
      m_data = '0;
      m_rw   = 1'b0;
      chk("mid_rst_addr", addr_o, 0);
      chk("mid_rst_data", data_o, 0);
      chk("mid_rst_rw", rw_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      send_str("345678\r");
      drain("after_rst");
      chk("final_valid", valid_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bridge_rx.md
BRIDGE_RX -- requirements
Module: bridge_rx

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: bus address width; SHALL be a multiple of 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: bus data width; SHALL be a multiple of 4.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_i  input  8  received ASCII byte from the UART receiver.
REQ-006 SHALL have port valid_i  input  1  data_i holds a new byte this cycle.
REQ-007 SHALL have port addr_o  output  ADDR_WIDTH  bus request address.
REQ-008 SHALL have port data_o  output  DATA_WIDTH  bus write data; zero for reads.
REQ-009 SHALL have port rw_o  output  1  1 = write, 0 = read.
REQ-010 SHALL have port valid_o  output  1  one-cycle bus request strobe to the first core in the chain.

Function
REQ-011 SHALL decode read messages 'R' + ADDR_WIDTH/4 hex digits + terminator, and write messages 'W' + ADDR_WIDTH/4 + DATA_WIDTH/4 hex digits + terminator; hex digits are MSB first.
REQ-012 SHALL accept 0x0D (CR) or 0x0A (LF) as terminator.
REQ-013 SHALL accept hex digits 0-9 and A-F; lowercase per REQ-025.
REQ-014 SHALL implement states IDLE, ADDR, DATA, TERM; bytes are consumed only when valid_i=1, one per cycle, with no backpressure.
REQ-015 IDLE: 'R' -> ADDR (rw=0); 'W' -> ADDR (rw=1); CR/LF and all other bytes are ignored and the state stays IDLE.
REQ-016 ADDR: a hex digit shifts its nibble into the address; after the last address digit, go to DATA if rw=1, otherwise to TERM.
REQ-017 DATA: a hex digit shifts its nibble into the data; after the last data digit, go to TERM.
REQ-018 TERM: a terminator asserts valid_o in the next cycle for exactly one cycle and returns to IDLE.
REQ-019 Any non-hex byte in ADDR/DATA, any non-terminator byte in TERM (including an extra digit), and any 'R'/'W' mid-message SHALL drop the message: no valid_o, return to IDLE.
REQ-020 A terminator arriving before the digit count is complete SHALL drop the message.
REQ-021 addr_o, data_o and rw_o SHALL be registered, SHALL change only in the cycle valid_o rises, and SHALL hold until the next completed message; data_o = 0 for reads.
REQ-022 The digit counter SHALL reset on every state entry; it SHALL NOT wrap into a shorter message.
REQ-023 A valid_i byte arriving in the same cycle valid_o is high SHALL be processed normally from IDLE.

Reset
REQ-024 While rst=1: state IDLE, counter 0, addr_o=0, data_o=0, rw_o=0, valid_o=0. A partial message is discarded, and no strobe is produced for it after reset releases.

Configuration
REQ-025 With BRIDGE_RX_LOWERCASE_EN defined, hex digits a-f and opcodes 'r'/'w' SHALL be accepted as equivalents of the uppercase forms. Without the macro, these characters SHALL be invalid bytes, handled per REQ-015 and REQ-019.

Structure
REQ-026 Package bridge_pkg SHALL hold the state enum and the ASCII constants ('R', 'W', CR, LF).
REQ-027 Sub-module hex_to_nibble (combinational: byte -> 4-bit value + is_hex flag) SHALL be used by bridge_rx; it honours BRIDGE_RX_LOWERCASE_EN.

Verification
REQ-028 Send "R0002\r" -> valid_o pulses once, one cycle after the CR byte; addr_o=0x0002, rw_o=0, data_o=0x0000.
REQ-029 Send "W12345678\n" -> one pulse; addr_o=0x1234, data_o=0x5678, rw_o=1; outputs are held after the pulse.
REQ-030 Send "R12G4\r" then "R00FF\r" -> no pulse for the first message; one pulse with addr_o=0x00FF for the second.
REQ-031 Send "R00011\r" (5 digits) and "W1234\r" (short) -> no pulses; addr_o/data_o keep their prior values.
REQ-032 Send "r00ab\r" -> with the macro, one pulse with addr_o=0x00AB; without the macro, no pulse.
REQ-033 Send "W12", pulse rst high for 2 cycles, then send "345678\r" -> no pulse, and all outputs are 0 from reset onward.
